// File: rtl/adc128s022_scanner.sv
// rtl/adc128s022_scanner.sv - round-robin SPI scan controller for the ADC128S022
//
// Walks the channels enabled in ch_mask, one 16-bit SPI frame per channel,
// and publishes each conversion as a one-cycle strobe tagged with its channel.
// The ADC returns the channel addressed in the previous frame, so the first
// frame after leaving IDLE only primes the pipeline and reports nothing.
//
// Ports:
//   CLOCK_50      system clock, all logic on its rising edge
//   RESET_N       asynchronous active-low reset
//   run           1 = scan continuously, 0 = stop after the current frame
//   ch_mask       channel enable, bit n = channel IN<n>
//   busy          high while a frame or the inter-frame gap is in progress
//   result_valid  one-cycle strobe qualifying result_ch/result_data
//   result_ch     channel of the result
//   result_data   12-bit unsigned conversion value
//   ADC_SCLK      SPI clock, idles high
//   ADC_SADDR     SPI data to the ADC (DIN)
//   ADC_CS_N      chip select, active low
//   ADC_SDAT      SPI data from the ADC (DOUT)
//
// Optional feature: define ADC_AVG_EN to report the mean of every four
// samples per channel instead of each raw sample.

module adc128s022_scanner #(
  parameter int CLK_DIV = 8,
  parameter int CS_GAP  = 16
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        run,
  input  logic [7:0]  ch_mask,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        ADC_SCLK,
  output logic        ADC_SADDR,
  output logic        ADC_CS_N,
  input  logic        ADC_SDAT
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          sclk_hi;
  logic [3:0]    bit_cnt;
  logic [2:0]    cur_ch;
  logic [2:0]    prev_ch;
  logic          prime;
  logic [11:0]   shift_reg;
  logic [2:0]    low_ch, next_ch, cand;
  logic [15:0]   addr_word;
  logic          last_div, last_gap, go, restart;

  assign go        = run && (ch_mask != 8'h00);
  assign last_div  = (cnt == CW'(CLK_DIV - 1));
  assign last_gap  = (cnt == CW'(CS_GAP - 1));
  assign addr_word = {2'b00, cur_ch, 11'b0};

  // Lowest enabled channel, and the first enabled channel above cur_ch with
  // wrap. Scanning offsets downward leaves the smallest matching offset; an
  // offset of 8 wraps to cur_ch itself so a lone channel repeats.
  always_comb begin
    low_ch  = 3'd0;
    next_ch = cur_ch;
    cand    = cur_ch;
    for (int i = 7; i >= 0; i--)
      if (ch_mask[i]) low_ch = 3'(i);
    for (int i = 8; i >= 1; i--) begin
      cand = cur_ch + 3'(i);
      if (ch_mask[cand]) next_ch = cand;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    ADC_CS_N  = 1'b1;
    ADC_SCLK  = 1'b1;
    ADC_SADDR = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nx = S_SETUP;
      end
      S_SETUP: begin
        ADC_CS_N = 1'b0;
        if (last_div) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        ADC_CS_N  = 1'b0;
        ADC_SCLK  = sclk_hi;
        ADC_SADDR = addr_word[bit_cnt];
        if (last_div && sclk_hi && bit_cnt == 4'd0) state_nx = S_HOLD;
      end
      S_HOLD: begin
        ADC_CS_N = 1'b0;
        if (last_div) state_nx = S_GAP;
      end
      S_GAP: begin
        if (last_gap) state_nx = go ? S_SETUP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The phase counter restarts on every state change and on every SCLK
  // half-period boundary inside SHIFT.
  assign restart = (state != state_nx) || (state == S_SHIFT && last_div);

`ifdef ADC_AVG_EN
  logic [13:0] acc [8];
  logic [1:0]  acc_cnt [8];
  logic [13:0] acc_sum;
  assign acc_sum = acc[prev_ch] + {2'b00, shift_reg};
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt          <= '0;
      sclk_hi      <= 1'b1;
      bit_cnt      <= 4'd15;
      cur_ch       <= 3'd0;
      prev_ch      <= 3'd0;
      prime        <= 1'b0;
      shift_reg    <= 12'd0;
      result_valid <= 1'b0;
      result_ch    <= 3'd0;
      result_data  <= 12'd0;
`ifdef ADC_AVG_EN
      for (int i = 0; i < 8; i++) begin
        acc[i]     <= 14'd0;
        acc_cnt[i] <= 2'd0;
      end
`endif
    end else begin
      cnt          <= (state == S_IDLE || restart) ? '0 : cnt + 1'b1;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            cur_ch <= low_ch;
            prime  <= 1'b0;
`ifdef ADC_AVG_EN
            for (int i = 0; i < 8; i++) begin
              acc[i]     <= 14'd0;
              acc_cnt[i] <= 2'd0;
            end
`endif
          end
        end
        S_SETUP: begin
          if (last_div) begin
            sclk_hi <= 1'b0;
            bit_cnt <= 4'd15;
          end
        end
        S_SHIFT: begin
          if (last_div) begin
            if (!sclk_hi) begin
              // Last clock before the SCLK rising edge: capture DOUT.
              sclk_hi   <= 1'b1;
              shift_reg <= {shift_reg[10:0], ADC_SDAT};
            end else begin
              sclk_hi <= 1'b0;
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (last_div) begin
            // This data belongs to the channel addressed one frame earlier.
            prime   <= 1'b1;
            prev_ch <= cur_ch;
            if (prime) begin
`ifdef ADC_AVG_EN
              if (acc_cnt[prev_ch] == 2'd3) begin
                result_valid     <= 1'b1;
                result_ch        <= prev_ch;
                result_data      <= acc_sum[13:2];
                acc[prev_ch]     <= 14'd0;
                acc_cnt[prev_ch] <= 2'd0;
              end else begin
                acc[prev_ch]     <= acc_sum;
                acc_cnt[prev_ch] <= acc_cnt[prev_ch] + 2'd1;
              end
`else
              result_valid <= 1'b1;
              result_ch    <= prev_ch;
              result_data  <= shift_reg;
`endif
            end
          end
        end
        S_GAP: begin
          if (last_gap) cur_ch <= next_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc128s022_scanner.sv
// tb/tb_adc128s022_scanner.sv - self-checking bench for adc128s022_scanner

module tb_adc128s022_scanner;

  localparam int CLK_DIV = 8;
  localparam int CS_GAP  = 16;
  localparam int FRAME   = CLK_DIV * 34 + CS_GAP;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        run      = 1'b0;
  logic [7:0]  ch_mask  = 8'h00;
  logic        busy, result_valid;
  logic [2:0]  result_ch;
  logic [11:0] result_data;
  logic        ADC_SCLK, ADC_SADDR, ADC_CS_N;
  logic        ADC_SDAT = 1'b0;

  adc128s022_scanner #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .run         (run),
    .ch_mask     (ch_mask),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ch   (result_ch),
    .result_data (result_data),
    .ADC_SCLK    (ADC_SCLK),
    .ADC_SADDR   (ADC_SADDR),
    .ADC_CS_N    (ADC_CS_N),
    .ADC_SDAT    (ADC_SDAT)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int nvec  = 0;
  int nfail = 0;

  // ADC model and bus monitor, both evaluated on the falling system clock.
  logic [2:0]  fr_addr [$];
  int          fr_falls [$];
  logic [2:0]  st_ch [$];
  logic [11:0] st_data [$];
  int          st_cyc [$];
  int          cyc = 0, frame_no = 0, avg_base = 0;
  int          fcnt = 0, low_run = 0;
  int          wide = 0, sclk_bad = 0, half_bad = 0, addr_bad = 0;
  int          cs_low_cycles = 0, busy_cycles = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_v = 1'b0;
  logic [2:0]  prev_addr = 3'd0;
  logic [15:0] word = 16'd0, din = 16'd0;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (prev_cs && !ADC_CS_N) begin
`ifdef ADC_AVG_EN
      word = {4'h0, 12'(100 * (frame_no - avg_base))};
`else
      word = {4'h0, 9'h100, prev_addr};
`endif
      fcnt = 0;
      din  = 16'd0;
    end
    if (!ADC_CS_N && prev_sclk && !ADC_SCLK) begin
      if (fcnt < 16) ADC_SDAT = word[4'(15 - fcnt)];
      fcnt++;
    end
    if (!ADC_CS_N && !prev_sclk && ADC_SCLK) din = {din[14:0], ADC_SADDR};
    if (!prev_cs && ADC_CS_N && RESET_N) begin
      fr_addr.push_back(din[13:11]);
      fr_falls.push_back(fcnt);
      if ((din & 16'hC7FF) != 16'd0) addr_bad++;
      prev_addr = din[13:11];
      frame_no++;
    end
    if (RESET_N) begin
      if (result_valid) begin
        st_ch.push_back(result_ch);
        st_data.push_back(result_data);
        st_cyc.push_back(cyc);
      end
      if (result_valid && prev_v) wide++;
      if (ADC_CS_N && !ADC_SCLK) sclk_bad++;
      if (!ADC_SCLK) low_run++;
      else begin
        if (low_run != 0 && low_run != CLK_DIV) half_bad++;
        low_run = 0;
      end
      if (!ADC_CS_N) cs_low_cycles++;
      if (busy) busy_cycles++;
    end else begin
      low_run = 0;
    end
    prev_v    = result_valid;
    prev_cs   = ADC_CS_N;
    prev_sclk = ADC_SCLK;
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int fr_at(input int i);
    return (i < fr_addr.size()) ? int'(fr_addr[i]) : -1;
  endfunction
  function automatic int falls_at(input int i);
    return (i < fr_falls.size()) ? fr_falls[i] : -1;
  endfunction
  function automatic int stc_at(input int i);
    return (i < st_ch.size()) ? int'(st_ch[i]) : -1;
  endfunction
  function automatic int std_at(input int i);
    return (i < st_data.size()) ? int'(st_data[i]) : -1;
  endfunction
  function automatic int sty_at(input int i);
    return (i < st_cyc.size()) ? st_cyc[i] : -1;
  endfunction

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    run     = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (fr_addr.size() < n && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (fr_addr.size() < n) check(tag, fr_addr.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (busy) check(tag, int'(busy), 0);
  endtask

  task automatic wait_cs_low(input int budget, input string tag);
    int k = 0;
    while (ADC_CS_N && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (ADC_CS_N) check(tag, int'(ADC_CS_N), 0);
  endtask

  // Each record: mask and the channels the first four frames must address,
  // packed first-to-last as four 3-bit fields.
  typedef struct {
    logic [7:0]  mask;
    logic [11:0] seq;
  } vec_t;

  vec_t vecs [6];

  function automatic int seq_ch(input logic [11:0] s, input int k);
    return int'((s >> (9 - 3 * k)) & 12'h7);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fb, sb, cb, bb, e;

    vecs[0] = '{8'h05, {3'd0, 3'd2, 3'd0, 3'd2}};
    vecs[1] = '{8'h80, {3'd7, 3'd7, 3'd7, 3'd7}};
    vecs[2] = '{8'h92, {3'd1, 3'd4, 3'd7, 3'd1}};
    vecs[3] = '{8'h01, {3'd0, 3'd0, 3'd0, 3'd0}};
    vecs[4] = '{8'hFF, {3'd0, 3'd1, 3'd2, 3'd3}};
    vecs[5] = '{8'h48, {3'd3, 3'd6, 3'd3, 3'd6}};

    do_reset();
    check("reset_cs_n",  int'(ADC_CS_N), 1);
    check("reset_sclk",  int'(ADC_SCLK), 1);
    check("reset_saddr", int'(ADC_SADDR), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_ch",    int'(result_ch), 0);
    check("reset_data",  int'(result_data), 0);

`ifdef ADC_AVG_EN
    do_reset();
    fb = fr_addr.size(); sb = st_ch.size(); avg_base = frame_no;
    ch_mask = 8'h01; run = 1'b1;
    wait_frames(fb + 5, 6 * FRAME, "avg_timeout");
    run = 1'b0;
    wait_idle(2 * FRAME, "avg_idle_timeout");
    check("avg_strobe_count", st_ch.size() - sb, 1);
    check("avg_ch",   stc_at(sb), 0);
    check("avg_data", std_at(sb), 250);
`else
    for (int i = 0; i < 6; i++) begin
      do_reset();
      fb = fr_addr.size(); sb = st_ch.size();
      ch_mask = vecs[i].mask; run = 1'b1;
      wait_frames(fb + 4, 5 * FRAME, $sformatf("v%0d_timeout", i));
      run = 1'b0;
      wait_idle(2 * FRAME, $sformatf("v%0d_idle_timeout", i));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_frame%0d_ch", i, k), fr_at(fb + k), seq_ch(vecs[i].seq, k));
        check($sformatf("v%0d_frame%0d_falls", i, k), falls_at(fb + k), 16);
      end
      check($sformatf("v%0d_strobe_count", i), st_ch.size() - sb, 3);
      for (int k = 0; k < 3; k++) begin
        e = seq_ch(vecs[i].seq, k);
        check($sformatf("v%0d_strobe%0d_ch", i, k), stc_at(sb + k), e);
        check($sformatf("v%0d_strobe%0d_data", i, k), std_at(sb + k), 12'h800 | e);
        if (k > 0)
          check($sformatf("v%0d_strobe%0d_spacing", i, k), sty_at(sb + k) - sty_at(sb + k - 1), FRAME);
      end
    end

    // Mask change mid-frame: the running frame keeps ch7, the next wraps to ch0.
    do_reset();
    fb = fr_addr.size(); sb = st_ch.size();
    ch_mask = 8'h80; run = 1'b1;
    wait_frames(fb + 1, 2 * FRAME, "mask_chg_timeout1");
    wait_cs_low(4 * CS_GAP, "mask_chg_cs_timeout");
    repeat (100) @(negedge CLOCK_50);
    ch_mask = 8'h03;
    wait_frames(fb + 3, 3 * FRAME, "mask_chg_timeout2");
    run = 1'b0;
    wait_idle(2 * FRAME, "mask_chg_idle_timeout");
    check("mask_chg_frame1_ch", fr_at(fb + 1), 7);
    check("mask_chg_frame2_ch", fr_at(fb + 2), 0);
    check("mask_chg_strobe_count", st_ch.size() - sb, 2);
    check("mask_chg_strobe1_ch", stc_at(sb + 1), 7);
    check("mask_chg_strobe1_data", std_at(sb + 1), 12'h807);

    // Drop run during SHIFT of a chained frame.
    do_reset();
    fb = fr_addr.size(); sb = st_ch.size();
    ch_mask = 8'h05; run = 1'b1;
    wait_frames(fb + 1, 2 * FRAME, "run_drop_timeout");
    wait_cs_low(4 * CS_GAP, "run_drop_cs_timeout");
    repeat (60) @(negedge CLOCK_50);
    run = 1'b0;
    wait_idle(2 * FRAME, "run_drop_idle_timeout");
    check("run_drop_frames", fr_addr.size() - fb, 2);
    check("run_drop_strobe_count", st_ch.size() - sb, 1);
    check("run_drop_strobe_ch", stc_at(sb), 0);
    check("run_drop_strobe_data", std_at(sb), 12'h800);
    cb = cs_low_cycles;
    repeat (600) @(negedge CLOCK_50);
    check("run_drop_cs_quiet", cs_low_cycles - cb, 0);
    check("run_drop_busy", int'(busy), 0);
    check("run_drop_cs_n", int'(ADC_CS_N), 1);

    // Empty mask: run alone must not start anything.
    do_reset();
    ch_mask = 8'h00; run = 1'b1;
    cb = cs_low_cycles; bb = busy_cycles;
    repeat (2000) @(negedge CLOCK_50);
    check("mask0_cs_low_cycles", cs_low_cycles - cb, 0);
    check("mask0_busy_cycles", busy_cycles - bb, 0);

    // Reset mid-SHIFT aborts at once; the next frame is a priming frame.
    ch_mask = 8'h05;
    wait_cs_low(4 * CLK_DIV, "rst_mid_cs_timeout");
    repeat (40) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    check("rst_mid_cs_n", int'(ADC_CS_N), 1);
    check("rst_mid_sclk", int'(ADC_SCLK), 1);
    check("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    fb = fr_addr.size(); sb = st_ch.size();
    wait_frames(fb + 1, 2 * FRAME, "rst_mid_timeout1");
    repeat (5) @(negedge CLOCK_50);
    check("rst_mid_priming_no_strobe", st_ch.size() - sb, 0);
    wait_frames(fb + 2, 2 * FRAME, "rst_mid_timeout2");
    repeat (2) @(negedge CLOCK_50);
    check("rst_mid_strobe_count", st_ch.size() - sb, 1);
    check("rst_mid_strobe_ch", stc_at(sb), 0);
    check("rst_mid_strobe_data", std_at(sb), 12'h800);
    run = 1'b0;
    wait_idle(2 * FRAME, "rst_mid_idle_timeout");
`endif

    check("strobe_width_errors", wide, 0);
    check("sclk_low_while_cs_high", sclk_bad, 0);
    check("sclk_half_period_errors", half_bad, 0);
    check("saddr_stray_bits", addr_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
